storage_type_detector: RTL and testbench
========================================

STORAGE_TYPE_DETECTOR -- requirements
Module: storage_type_detector

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: number of cycles the detector drives the initialise value before launching the test edge.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one classification run, sampled only in IDLE.
REQ-005 SHALL have port obs_q, input, 1 bit: output of the storage element under test, synchronous to clk; no synchroniser.
REQ-006 SHALL have port stim_en, output, 1 bit: enable driven to the element under test, registered.
REQ-007 SHALL have port stim_d, output, 1 bit: data driven to the element under test, registered.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse when result updates.
REQ-010 SHALL have port result, output, 2 bits: 2'b00 UNKNOWN, 2'b01 LATCH, 2'b10 FLOP, 2'b11 COMB (transparent, ignores enable); held until the next done.

Function
REQ-011 SHALL implement states IDLE, INIT, LAUNCH, FOLLOW, HOLD1, HOLD2; each transition occurs on a rising edge.
REQ-012 SHALL leave IDLE for INIT when start=1 in IDLE; start while busy=1 SHALL be ignored, with no queueing.
REQ-013 SHALL drive per state (P = polarity, 0 for a single pass): IDLE en=0 d=0; INIT en=1 d=P for SETTLE_CYCLES cycles; LAUNCH en=1 d=~P; FOLLOW en=1 d=~P; HOLD1 en=0 d=~P; HOLD2 en=0 d=P.
REQ-014 SHALL capture obs_q XOR P at the edge leaving each state: s0 (last INIT cycle), s1 (LAUNCH), s2 (FOLLOW), s3 (HOLD2).
REQ-015 SHALL classify, in priority order: s0=1 -> UNKNOWN; s1=1 and s3=0 -> COMB; s1=1 and s3=1 -> LATCH; s1=0, s2=1, s3=1 -> FLOP; otherwise UNKNOWN.
REQ-016 SHALL, at the edge leaving the final HOLD2, load result, pulse done for exactly one cycle, and return to IDLE.
REQ-017 SHALL assert done for a single pass at the (SETTLE_CYCLES+4)th edge after the edge that sampled start: 6 edges for the default.
REQ-018 SHALL implement the INIT cycle counter with 4-bit width and no wrap; the counter resets on every entry to INIT.
REQ-019 SHALL accept start while done=1, because the state is already IDLE.

Reset
REQ-020 SHALL force, whenever rst_n=0 and independent of clk: state IDLE, stim_en=0, stim_d=0, busy=0, done=0, result=2'b00, captured samples and counter 0.
REQ-021 SHALL abort a run when reset is asserted mid-run, without producing a done; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-022 SHALL use macro DETECT_DUAL_POLARITY_EN to select pass count.
REQ-023 SHALL, when DETECT_DUAL_POLARITY_EN is defined, run pass 1 with P=0, then go from HOLD2 to INIT with P=1. The result SHALL be the pass-1 class if both passes agree, else UNKNOWN. done SHALL occur 2*(SETTLE_CYCLES+4) edges after start, with no done after pass 1.
REQ-024 SHALL, when DETECT_DUAL_POLARITY_EN is undefined, run a single pass with P=0 only; the polarity register and second-pass logic SHALL be absent.

Verification
REQ-025 SHALL cover a behavioural level-sensitive latch (if en q=d) on stim_en/stim_d, start pulse: done at edge 6, result=2'b01, busy high edges 1-6.
REQ-026 SHALL cover a posedge flop with enable on clk: result=2'b10 at edge 6.
REQ-027 SHALL cover obs_q wired directly to stim_d: result=2'b11; obs_q tied to 1: result=2'b00 (s0=1); obs_q tied to 0: result=2'b00.
REQ-028 SHALL cover a second start pulse at edge 3 while busy: no effect, a single done at edge 6; start in the done cycle: new run, next done 6 edges later.
REQ-029 SHALL cover rst_n pulsed low at edge 4: stim_en, stim_d, busy, done and result all 0 immediately, with no done afterward.
REQ-030 SHALL cover, with DETECT_DUAL_POLARITY_EN defined, a latch: result=2'b01 at edge 12. A model stuck at 1 after its first write SHALL give result=2'b00.

Source files
------------

// File: rtl/storage_type_detector.sv
// Classifies the storage element wired to stim_en/stim_d/obs_q as latch, flop or combinational.
// Define DETECT_DUAL_POLARITY_EN to repeat the test with inverted polarity and require agreement.
module storage_type_detector #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       obs_q,
    output logic       stim_en,
    output logic       stim_d,
    output logic       busy,
    output logic       done,
    output logic [1:0] result
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] RES_UNKNOWN = 2'b00;
    localparam logic [1:0] RES_LATCH   = 2'b01;
    localparam logic [1:0] RES_FLOP    = 2'b10;
    localparam logic [1:0] RES_COMB    = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LAUNCH = 3'd2,
        FOLLOW = 3'd3,
        HOLD1  = 3'd4,
        HOLD2  = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             s0, s1, s2;
    logic             s0_n, s1_n, s2_n;
    logic             stim_en_n, stim_d_n, busy_n, done_n;
    logic [1:0]       result_n;
    logic             pass_pol, next_pol;
    logic             sample;
    logic [1:0]       cls;

    // Samples are taken relative to the pass polarity so one rule set serves both passes.
    function automatic logic [1:0] classify(input logic c0, input logic c1,
                                            input logic c2, input logic c3);
        logic [1:0] r;
        r = RES_UNKNOWN;
        if (c0)                r = RES_UNKNOWN;
        else if (c1 && !c3)    r = RES_COMB;
        else if (c1 && c3)     r = RES_LATCH;
        else if (c2 && c3)     r = RES_FLOP;
        return r;
    endfunction

`ifdef DETECT_DUAL_POLARITY_EN
    logic       pol;
    logic [1:0] cls1, cls1_n;

    assign pass_pol = pol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol  <= 1'b0;
            cls1 <= RES_UNKNOWN;
        end else begin
            pol  <= next_pol;
            cls1 <= cls1_n;
        end
    end
`else
    assign pass_pol = 1'b0;
`endif

    assign sample = obs_q ^ pass_pol;
    assign cls    = classify(s0, s1, s2, sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            s0      <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            stim_en <= 1'b0;
            stim_d  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= RES_UNKNOWN;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            s0      <= s0_n;
            s1      <= s1_n;
            s2      <= s2_n;
            stim_en <= stim_en_n;
            stim_d  <= stim_d_n;
            busy    <= busy_n;
            done    <= done_n;
            result  <= result_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        s0_n      = s0;
        s1_n      = s1;
        s2_n      = s2;
        done_n    = 1'b0;
        result_n  = result;
        next_pol  = pass_pol;
        stim_en_n = 1'b0;
        stim_d_n  = 1'b0;
`ifdef DETECT_DUAL_POLARITY_EN
        cls1_n    = cls1;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = INIT;
                    cnt_n   = '0;
                end
            end
            INIT: begin
                if (cnt >= CNT_LAST) begin
                    s0_n    = sample;
                    state_n = LAUNCH;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            LAUNCH: begin
                s1_n    = sample;
                state_n = FOLLOW;
            end
            FOLLOW: begin
                s2_n    = sample;
                state_n = HOLD1;
            end
            HOLD1: begin
                state_n = HOLD2;
            end
            HOLD2: begin
`ifdef DETECT_DUAL_POLARITY_EN
                if (!pass_pol) begin
                    cls1_n   = cls;
                    next_pol = 1'b1;
                    cnt_n    = '0;
                    state_n  = INIT;
                end else begin
                    result_n = (cls == cls1) ? cls : RES_UNKNOWN;
                    done_n   = 1'b1;
                    next_pol = 1'b0;
                    state_n  = IDLE;
                end
`else
                result_n = cls;
                done_n   = 1'b1;
                state_n  = IDLE;
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Drive values are decoded from the next state so they are registered in step with it.
        case (state_n)
            INIT: begin
                stim_en_n = 1'b1;
                stim_d_n  = next_pol;
            end
            LAUNCH, FOLLOW: begin
                stim_en_n = 1'b1;
                stim_d_n  = ~next_pol;
            end
            HOLD1: begin
                stim_d_n = ~next_pol;
            end
            HOLD2: begin
                stim_d_n = next_pol;
            end
            default: begin
                stim_en_n = 1'b0;
                stim_d_n  = 1'b0;
            end
        endcase
    end

    assign busy_n = (state_n != IDLE);

endmodule

// File: tb/tb_storage_type_detector.sv
// Scoreboard bench for storage_type_detector: behavioural elements on the stimulus pins,
// a pass-level reference model, and a negedge monitor checking every output each cycle.
module tb_storage_type_detector;

    localparam int S = 2;
`ifdef DETECT_DUAL_POLARITY_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int PL = S + 4;
    localparam int L  = NPASS * PL;
    localparam int NK = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       obs_q;
    logic       stim_en, stim_d, busy, done;
    logic [1:0] result;

    int   kind_sel = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic lat_q = 1'b0;
    logic flop_q = 1'b0;
    logic stk_q = 1'b0;

    typedef struct {
        int         st;
        logic [1:0] res;
    } exp_t;
    exp_t sb[$];

    storage_type_detector #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .obs_q(obs_q),
        .stim_en(stim_en), .stim_d(stim_d), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Elements under test: 0 latch, 1 flop, 2 wire, 3 tie-1, 4 tie-0, 5 latch stuck at 1 once written 1.
    always @(stim_en or stim_d or rst_n) begin
        if (!rst_n) lat_q = 1'b0;
        else if (stim_en) lat_q = stim_d;
    end
    always @(stim_en or stim_d or rst_n) begin
        if (!rst_n) stk_q = 1'b0;
        else if (stim_en) stk_q = stk_q | stim_d;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) flop_q <= 1'b0;
        else if (stim_en) flop_q <= stim_d;
    end
    always_comb begin
        case (kind_sel)
            0:       obs_q = lat_q;
            1:       obs_q = flop_q;
            2:       obs_q = stim_d;
            3:       obs_q = 1'b1;
            4:       obs_q = 1'b0;
            default: obs_q = stk_q;
        endcase
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: persistent element contents plus the class each element earns in a pass.
    bit         m_lat, m_flop, m_stk;
    logic [1:0] pass_cls [NK];

    function automatic logic [1:0] rule(bit a0, bit a1, bit a2, bit a3);
        if (a0) return 2'b00;
        if (a1) return a3 ? 2'b01 : 2'b11;
        if (a2 && a3) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_lat = 1'b0;
        m_flop = 1'b0;
        m_stk = 1'b0;
    endtask

    task automatic model_pass(input bit p);
        bit q [NK][PL];
        bit en, d;
        for (int k = 0; k < PL; k++) begin
            en = (k < S + 2);
            d  = (k < S || k == S + 3) ? p : ~p;
            if (en) m_lat = d;
            q[0][k] = m_lat;
            q[1][k] = m_flop;
            if (en) m_flop = d;
            q[2][k] = d;
            q[3][k] = 1'b1;
            q[4][k] = 1'b0;
            if (en) m_stk = m_stk | d;
            q[5][k] = m_stk;
        end
        for (int e = 0; e < NK; e++)
            pass_cls[e] = rule(q[e][S-1] ^ p, q[e][S] ^ p, q[e][S+1] ^ p, q[e][S+3] ^ p);
    endtask

    task automatic model_run(input int kind, output logic [1:0] res);
        logic [1:0] first;
        model_pass(1'b0);
        first = pass_cls[kind];
        res = first;
        if (NPASS == 2) begin
            model_pass(1'b1);
            res = (pass_cls[kind] == first) ? first : 2'b00;
        end
    endtask

    // Monitor: expected outputs derive from the head scoreboard entry's start edge.
    logic [1:0] last_res = 2'b00;
    logic [5:0] mexp;
    int         mk, mkp;
    bit         mp;
    always @(negedge clk) begin
        if (!rst_n) last_res = 2'b00;
        mexp = {4'b0000, last_res};
        if (sb.size() > 0 && cyc >= sb[0].st) begin
            mk = cyc - sb[0].st;
            if (mk < L) begin
                mkp = mk % PL;
                mp  = (mk / PL) != 0;
                mexp[5] = (mkp < S + 2);
                mexp[4] = (mkp < S || mkp == S + 3) ? mp : ~mp;
                mexp[3] = 1'b1;
            end else begin
                chk("result", {6'd0, result}, {6'd0, sb[0].res});
                last_res = sb[0].res;
                mexp = {4'b0001, last_res};
                void'(sb.pop_front());
            end
        end
        chk("outputs", {2'b00, stim_en, stim_d, busy, done, result}, {2'b00, mexp});
    end

    task automatic issue(input int kind);
        exp_t e;
        kind_sel = kind;
        e.st = cyc + 1;
        model_run(kind, e.res);
        sb.push_back(e);
        start = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that raised done.
    task automatic run(input int kind, input int gap, input int xj);
        bit seen;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        issue(kind);
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 1; i <= L + 4 && !seen; i++) begin
            start = (i == xj);
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout at cycle %0d: got no done expected one within %0d edges", cyc, L + 4);
            sb.delete();
        end
    endtask

    task automatic reset_mid(input int kind);
        issue(kind);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_stim_en", {7'd0, stim_en}, 8'd0);
        chk("rst_stim_d", {7'd0, stim_d}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_result", {6'd0, result}, 8'd0);
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (L + 3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        chk("init_stim_en", {7'd0, stim_en}, 8'd0);
        chk("init_busy", {7'd0, busy}, 8'd0);
        chk("init_done", {7'd0, done}, 8'd0);
        chk("init_result", {6'd0, result}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 1, 0);
        run(1, 2, 0);
        run(2, 0, 0);
        run(3, 1, 0);
        run(4, 0, 0);
        run(0, 2, 3);
        run(1, 0, 0);
        run(0, 0, 0);
        reset_mid(0);
        run(5, 0, 0);
        run(5, 1, 0);
        reset_mid(1);

        for (int n = 0; n < 40; n++) begin
            int k, g, x;
            k = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) k = 5;
            g = $urandom_range(0, 3);
            x = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, L)) : 0;
            run(k, g, x);
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
